// File: rtl/scan_decoder_n.sv
// -----------------------------------------------------------------------------
// scan_decoder_n
//   Registered N-way digit-select decoder with a built-in scan sequencer for a
//   multiplexed display. In auto mode the selected digit advances once per
//   prescaler period and wraps after the last digit. In manual mode the digit
//   index comes from sel_in; out-of-range indices are ignored. The tick and
//   frame strobes let the segment-data path stay aligned with the selected
//   digit.
//
//   Optional feature macro: SCAN_DEADTIME_EN
//     When defined, dig_en is held inactive for DEAD_CYC clocks after every
//     change of sel (anti-ghosting). DEAD_CYC must be smaller than DIV.
//
// Parameters
//   DIGITS      number of digit positions (2..16)
//   SEL_W       digit index width, 2**SEL_W >= DIGITS
//   DIV         clocks per digit slot (>= 1)
//   ACTIVE_LOW  1 = dig_en active-low
//   DEAD_CYC    dead-time clocks (only with SCAN_DEADTIME_EN)
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous reset, active-low
//   blank   in   1 = all digit enables inactive; scanning continues
//   mode    in   0 = auto scan, 1 = manual select
//   sel_in  in   manual digit index
//   dig_en  out  one-hot digit enable (registered)
//   sel     out  current digit index (registered)
//   tick    out  one-clock pulse at each slot boundary
//   frame   out  one-clock pulse when auto scan wraps DIGITS-1 -> 0
//
// Handshake: none. All outputs are registered and change only on clk edges;
// dig_en, sel, tick and frame always update on the same edge.
// -----------------------------------------------------------------------------
module scan_decoder_n #(
    parameter int DIGITS     = 6,
    parameter int SEL_W      = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int DEAD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blank,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel_in,
    output logic [DIGITS-1:0] dig_en,
    output logic [SEL_W-1:0]  sel,
    output logic              tick,
    output logic              frame
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(DIGITS - 1);
    // One extra bit so DIGITS == 2**SEL_W is still representable.
    localparam logic [SEL_W:0]    DIGITS_X = (SEL_W + 1)'(DIGITS);
    localparam logic [DIGITS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DIGITS-1:0] dig_en_q, dig_en_d;
    logic              tick_q, frame_q, frame_d;
    logic              cnt_wrap;
    logic              dark;
    logic [DIGITS-1:0] onehot;

    // Prescaler and digit sequencing.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        sel_d    = sel_q;
        frame_d  = 1'b0;
        if (mode) begin
            // Out-of-range manual indices leave the selection untouched.
            if ({1'b0, sel_in} < DIGITS_X) begin
                sel_d = sel_in;
            end
        end else if (cnt_wrap) begin
            if (sel_q == LAST_SEL) begin
                sel_d   = '0;
                frame_d = 1'b1;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end
    end

    // Decode the next-state index so dig_en lines up with sel on the same edge.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (sel_d == SEL_W'(k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

`ifdef SCAN_DEADTIME_EN
    localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    logic [DEAD_W-1:0] dead_q, dead_d;

    // A change of sel starts (or restarts) the dark window; the edge that
    // changes sel is itself the first dark clock.
    always_comb begin
        dead_d = dead_q;
        dark   = blank;
        if ((sel_d != sel_q) && (DEAD_CYC > 0)) begin
            dead_d = DEAD_LOAD;
            dark   = 1'b1;
        end else if (dead_q != '0) begin
            dead_d = dead_q - 1'b1;
            dark   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`else
    localparam int unused_dead_cyc = DEAD_CYC;

    always_comb begin
        dark = blank;
    end
`endif

    always_comb begin
        dig_en_d = dark ? INACTIVE : (onehot ^ INACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            tick_q   <= 1'b0;
            frame_q  <= 1'b0;
            dig_en_q <= INACTIVE;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            tick_q   <= cnt_wrap;
            frame_q  <= frame_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign dig_en = dig_en_q;
    assign sel    = sel_q;
    assign tick   = tick_q;
    assign frame  = frame_q;

endmodule
